// File: rtl/jogo_memoria_pkg.sv
// rtl/jogo_memoria_pkg.sv - shared state codes and expected-value helper for jogo_memoria_param
package jogo_memoria_pkg;

   // Fixed codes so db_estado stays stable across builds
   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARA        = 4'd1,
      MOSTRA_LIGA    = 4'd2,
      MOSTRA_DESLIGA = 4'd3,
      ESPERA         = 4'd4,
      COMPARA        = 4'd5,
      PROX_RODADA    = 4'd6,
      FIM_GANHOU     = 4'd7,
      FIM_PERDEU     = 4'd8
   } estado_t;

   // One-hot button pattern for a sequence entry (callers keep the low N_BOTOES bits)
   function automatic logic [31:0] onehot_esperado(input logic [31:0] entrada);
      return 32'd1 << entrada;
   endfunction

endpackage

// File: rtl/jogo_memoria_param_sequencia_rom.sv
// rtl/jogo_memoria_param_sequencia_rom.sv - combinational sequence ROM, entry i = i mod N_BOTOES
module sequencia_rom #(
   parameter int N_BOTOES  = 4,
   parameter int N_RODADAS = 16,
   localparam int RW = (N_RODADAS > 1) ? $clog2(N_RODADAS) : 1,
   localparam int BW = $clog2(N_BOTOES)
) (
   input  logic [RW-1:0] i_endereco,
   output logic [BW-1:0] o_entrada
);

   logic [BW-1:0] w_rom [N_RODADAS];

   for (genvar gi = 0; gi < N_RODADAS; gi++) begin : g_rom
      assign w_rom[gi] = BW'(gi % N_BOTOES);
   end

   // Addresses past the last round never occur in play; return 0 rather than X
   assign o_entrada = (int'(i_endereco) < N_RODADAS) ? w_rom[i_endereco] : '0;

endmodule

// File: rtl/jogo_memoria_param.sv
// rtl/jogo_memoria_param.sv - sequence-memory game controller; JOGO_TIMEOUT_EN enables the press timeout
module jogo_memoria_param
   import jogo_memoria_pkg::*;
#(
   parameter int N_BOTOES       = 4,
   parameter int N_RODADAS      = 16,
   parameter int MOSTRA_CICLOS  = 1000,
   parameter int TIMEOUT_CICLOS = 5000,
   localparam int RW = (N_RODADAS > 1) ? $clog2(N_RODADAS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                jogar,
   input  logic [N_BOTOES-1:0] botoes,
   output logic [N_BOTOES-1:0] leds,
   output logic                pronto,
   output logic                ganhou,
   output logic                perdeu,
   output logic [3:0]          db_estado,
   output logic [RW-1:0]       db_rodada,
   output logic [RW-1:0]       db_jogada,
   output logic                db_timeout
);

   localparam int BW = $clog2(N_BOTOES);
   localparam int MW = (MOSTRA_CICLOS > 1) ? $clog2(MOSTRA_CICLOS) : 1;

   estado_t             r_estado;
   logic [RW-1:0]       r_rodada;
   logic [RW-1:0]       r_jogada;
   logic [MW-1:0]       r_mostra;
   logic [N_BOTOES-1:0] r_botoes_q;
   logic [N_BOTOES-1:0] r_captura;
   logic                r_jogar_q;
   logic                r_timeout;

   logic [BW-1:0]       w_entrada;
   logic [31:0]         w_esperado;
   logic                w_jogar_borda;
   logic                w_press;
   logic                w_acerto;
   logic                w_ultima;
   logic                w_final;
   logic                w_mostra_fim;
   logic                w_estouro;

   sequencia_rom #(
      .N_BOTOES  (N_BOTOES),
      .N_RODADAS (N_RODADAS)
   ) u_rom (
      .i_endereco (r_jogada),
      .o_entrada  (w_entrada)
   );

   assign w_esperado    = onehot_esperado(32'(w_entrada));
   assign w_jogar_borda = jogar & ~r_jogar_q;
   assign w_press       = (|botoes) & ~(|r_botoes_q);
   assign w_acerto      = (32'(r_captura) == w_esperado);
   assign w_ultima      = (r_jogada == r_rodada);
   assign w_final       = (r_rodada == RW'(N_RODADAS - 1));
   assign w_mostra_fim  = (r_mostra == MW'(MOSTRA_CICLOS - 1));

`ifdef JOGO_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

   logic [TW-1:0] r_espera;

   // Idle counter: restarts whenever we are outside ESPERA or a press is accepted
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_espera <= '0;
      else if (r_estado != ESPERA || w_press)
         r_espera <= '0;
      else
         r_espera <= r_espera + TW'(1);
   end

   assign w_estouro  = (r_espera == TW'(TIMEOUT_CICLOS - 1));
   assign db_timeout = r_timeout;
`else
   assign w_estouro  = 1'b0;
   assign db_timeout = 1'b0;
`endif

   // Game FSM with round/play indices, display timer and press capture
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado   <= INICIAL;
         r_rodada   <= '0;
         r_jogada   <= '0;
         r_mostra   <= '0;
         r_botoes_q <= '0;
         r_captura  <= '0;
         r_jogar_q  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_jogar_q  <= jogar;
         r_botoes_q <= botoes;
         case (r_estado)
            INICIAL: begin
               if (w_jogar_borda) r_estado <= PREPARA;
            end
            PREPARA: begin
               r_rodada  <= '0;
               r_jogada  <= '0;
               r_mostra  <= '0;
               r_captura <= '0;
               r_timeout <= 1'b0;
               r_estado  <= MOSTRA_LIGA;
            end
            MOSTRA_LIGA: begin
               if (w_mostra_fim) begin
                  r_mostra <= '0;
                  r_estado <= MOSTRA_DESLIGA;
               end else begin
                  r_mostra <= r_mostra + MW'(1);
               end
            end
            MOSTRA_DESLIGA: begin
               if (w_mostra_fim) begin
                  r_mostra <= '0;
                  if (w_ultima) begin
                     r_jogada <= '0;
                     r_estado <= ESPERA;
                  end else begin
                     r_jogada <= r_jogada + RW'(1);
                     r_estado <= MOSTRA_LIGA;
                  end
               end else begin
                  r_mostra <= r_mostra + MW'(1);
               end
            end
            ESPERA: begin
               // A press on the same cycle as the timeout takes priority
               if (w_press) begin
                  r_captura <= botoes;
                  r_estado  <= COMPARA;
               end else if (w_estouro) begin
                  r_timeout <= 1'b1;
                  r_estado  <= FIM_PERDEU;
               end
            end
            COMPARA: begin
               if (!w_acerto) begin
                  r_estado <= FIM_PERDEU;
               end else if (!w_ultima) begin
                  r_jogada <= r_jogada + RW'(1);
                  r_estado <= ESPERA;
               end else if (!w_final) begin
                  r_estado <= PROX_RODADA;
               end else begin
                  r_estado <= FIM_GANHOU;
               end
            end
            PROX_RODADA: begin
               r_rodada <= r_rodada + RW'(1);
               r_jogada <= '0;
               r_estado <= MOSTRA_LIGA;
            end
            FIM_GANHOU, FIM_PERDEU: begin
               if (w_jogar_borda) r_estado <= PREPARA;
            end
            default: r_estado <= INICIAL;
         endcase
      end
   end

   // Moore output decode: LEDs show the sequence item, echo buttons while waiting
   always_comb begin
      leds = '0;
      case (r_estado)
         MOSTRA_LIGA: leds = w_esperado[N_BOTOES-1:0];
         ESPERA:      leds = botoes;
         default:     leds = '0;
      endcase
   end

   assign pronto    = (r_estado == FIM_GANHOU) || (r_estado == FIM_PERDEU);
   assign ganhou    = (r_estado == FIM_GANHOU);
   assign perdeu    = (r_estado == FIM_PERDEU);
   assign db_estado = r_estado;
   assign db_rodada = r_rodada;
   assign db_jogada = r_jogada;

endmodule

// File: doc/jogo_memoria_param.md
# jogo_memoria_param

Parametrised sequence-memory game controller (Genius-style) for the lab FPGA top level. It replays a stored button sequence on the LEDs, then checks the player's presses round by round. Each round is one item longer than the previous. It ends in win, wrong-press loss or timeout loss. Button count, round count, display time and timeout are all generics, and the sequence replay phase is handled internally.

## Interface
Parameters:
- N_BOTOES, 4, number of buttons/LEDs (≥2)
- N_RODADAS, 16, rounds to win (≥1); sequence depth
- MOSTRA_CICLOS, 1000, cycles each sequence item is lit, and also the gap after it
- TIMEOUT_CICLOS, 5000, idle cycles allowed per press

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- jogar  in  1  start request, level; rising edge is used
- botoes  in  N_BOTOES  player buttons, one-hot expected
- leds  out  N_BOTOES  LED drive
- pronto  out  1  game finished
- ganhou  out  1  win flag
- perdeu  out  1  loss flag
- db_estado  out  4  current state code
- db_rodada  out  $clog2(N_RODADAS)  current round index
- db_jogada  out  $clog2(N_RODADAS)  current play/display index
- db_timeout  out  1  loss was caused by timeout

## Operation
- Sequence: the ROM entry i is `i mod N_BOTOES`. The expected one-hot value is `1 << entry`.
- Round r (0-based) requires r+1 correct presses, for items 0..r.
- States and transitions:
  - INICIAL: waits for a jogar rising edge, then goes to PREPARA.
  - PREPARA: one cycle. Clears rodada, jogada, counters and flags. Goes to MOSTRA_LIGA.
  - MOSTRA_LIGA: leds = onehot(ROM[jogada]) for MOSTRA_CICLOS cycles, then MOSTRA_DESLIGA.
  - MOSTRA_DESLIGA: leds = 0 for MOSTRA_CICLOS cycles.
    - If jogada == rodada: jogada clears to 0 and the state goes to ESPERA.
    - Otherwise: jogada increments and the state goes back to MOSTRA_LIGA.
  - ESPERA: leds = botoes (echo).
    - On a press edge: capture botoes and go to COMPARA.
    - On timeout: go to FIM_PERDEU with db_timeout set.
  - COMPARA: compares the captured value with the expected value. The next state is:
    - FIM_PERDEU on mismatch;
    - ESPERA with jogada+1 on match and jogada < rodada;
    - PROX_RODADA on match, jogada == rodada, and rodada < N_RODADAS-1;
    - FIM_GANHOU on match, jogada == rodada, and rodada == N_RODADAS-1.
  - PROX_RODADA: rodada+1, jogada cleared, then MOSTRA_LIGA.
  - FIM_GANHOU / FIM_PERDEU: pronto=1 with ganhou or perdeu held. A jogar rising edge goes to PREPARA.
- Press edge: a registered copy of botoes is kept. A press is botoes ≠ 0 while the registered copy == 0.
  - A held button counts once.
  - Presses outside ESPERA are ignored and are not queued.
  - A multi-bit press is captured as-is and fails the compare.
- jogar edges are ignored outside INICIAL and FIM_*.
- Timeout counter:
  - Cleared on entering ESPERA and on every accepted press.
  - Increments each cycle while in ESPERA.
  - At TIMEOUT_CICLOS-1 the state goes to FIM_PERDEU.

## Timing
- Reset values: every output is 0, state is INICIAL, and all counters and the registered copy of botoes are 0. Reset asserted mid-game returns to INICIAL immediately.
- jogar edge to first LED lit: 2 edges (through PREPARA).
- Press sampled at edge E0 → COMPARA after E0. The result state is entered after E1, so ganhou/perdeu/pronto rise 2 edges after the press is sampled.
- Flags are Moore outputs decoded from state, so they are glitch-free.
- A press and a timeout on the same cycle: the press wins.
- Round r display lasts (r+1)·2·MOSTRA_CICLOS cycles.

## Configuration
- JOGO_TIMEOUT_EN defined: the timeout counter and timeout transition are present, and db_timeout behaves as above.
- JOGO_TIMEOUT_EN undefined: no counter is synthesised, ESPERA waits indefinitely, and db_timeout is tied to 0.

## Structure
- Package jogo_memoria_pkg holds:
  - the state enum typedef with fixed 4-bit codes used by db_estado;
  - a helper function returning the one-hot expected value.
- Sub-module sequencia_rom: combinational ROM, N_RODADAS entries of $clog2(N_BOTOES) bits, addressed by jogada.
- Counters and the FSM stay in the top module.

## Test plan
All scenarios use N_BOTOES=4, N_RODADAS=4, MOSTRA_CICLOS=10, TIMEOUT_CICLOS=50, JOGO_TIMEOUT_EN defined, and presses held 5 cycles.
- Full win: reset, jogar for 5 cycles, then press the correct sequence (0001, 0010, 0100, 1000) prefixes each round → ganhou=1, pronto=1, perdeu=0, db_rodada=3.
- Wrong press: round 2 (0-based), play 1, press 0001 instead of 0010 → perdeu=1 exactly 2 edges after sampling, db_timeout=0, db_rodada=2.
- Timeout: start the game, let round 0 display finish, press nothing → perdeu=1 and db_timeout=1 after 50 cycles in ESPERA.
- Display check: after jogar, round 1 → leds=0001 for 10 cycles, 0000 for 10, 0010 for 10, 0000 for 10, then ESPERA.
- Held button / early press: press during MOSTRA_LIGA is ignored. A 0001 held for 40 cycles in ESPERA counts once (db_jogada advances by 1 only).
- Restart and async reset: jogar in FIM_PERDEU → flags clear and the game replays round 0. reset asserted mid-display → all outputs 0 before the next clock edge.
